// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I memory opcodes, the func3 access-size codes, the sequencer
// state type, the fault cause encoding and a func3 legality helper.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_ILLEGAL  = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fault_cause_t;

    // Stores only have signed-width forms; loads additionally allow BU/HU.
    function automatic logic func3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory port of the load/store unit.
//   mem_req    LSU -> memory  transfer request, held until mem_ready
//   mem_we     LSU -> memory  1 = write
//   mem_addr   LSU -> memory  word-aligned byte address
//   mem_wdata  LSU -> memory  lane-replicated store data
//   mem_be     LSU -> memory  byte enables
//   mem_ready  memory -> LSU  transfer accepted/completed this cycle
//   mem_rdata  memory -> LSU  read data, valid with mem_ready
interface lsu_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   we          1 = store access
//   func3       access size / signedness
//   off         effective address bits [1:0]
//   store_data  raw rs2 value
//   rdata       raw memory read word
//   be          byte enables (all lanes for loads)
//   wdata       store data replicated across the lanes
//   load_value  extracted and sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_value
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Sub-word stores replicate the datum so whichever lanes are enabled see it.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        if (we) begin
            case (func3)
                F3_B: begin
                    be    = 4'b0001 << off;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be    = 4'b0011 << off;
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = store_data;
                end
            endcase
        end
    end

    // Halfword loads are already known aligned, so off[1] picks the half.
    always_comb begin
        rbyte = 8'(rdata >> {off, 3'b000});
        rhalf = off[1] ? rdata[31:16] : rdata[15:0];
        case (func3[1:0])
            2'b00:   load_value = func3[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   load_value = func3[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: load_value = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer for the RV32I core.
//   clk, rst      core clock, asynchronous active-low reset
//   start         decoded instruction valid
//   opcode/func3  decoded fields
//   base_addr     rs1, immediate (12-bit, sign-extended here), store_data (rs2)
//   busy          stall request to PC/fetch
//   done, wb_en   one-cycle completion pulse / register write enable (loads)
//   load_data     extended load result, held until the next load completes
//   fault         one-cycle fault pulse with fault_cause
//   mem           data-memory port (master side)
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] base_addr,
    input  logic [11:0] immediate,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    lsu_if.master       mem
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] CNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state;
    fault_cause_t      cause_q;
    logic [TCNT_W-1:0] wait_cnt;
    logic [31:0]       ea_q;
    logic [2:0]        func3_q;
    logic              we_q;
    logic [31:0]       sdata_q;
    logic [31:0]       load_q;

    logic [31:0] ea;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        illegal;
    logic        misaligned;
    logic        bus_active;
    logic [3:0]  steer_be;
    logic [31:0] steer_wdata;
    logic [31:0] steer_load;

    // Decode of the instruction being offered in IDLE.
    always_comb begin
        ea         = base_addr + {{20{immediate[11]}}, immediate};
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        is_mem     = is_load || is_store;
        illegal    = !func3_legal(is_store, func3);
        misaligned = ((func3[1:0] == 2'b01) && ea[0]) ||
                     ((func3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    end

    // Lane logic runs from the latched access so the bus stays stable in BUS.
    lsu_align u_align (
        .we         (we_q),
        .func3      (func3_q),
        .off        (ea_q[1:0]),
        .store_data (sdata_q),
        .rdata      (mem.mem_rdata),
        .be         (steer_be),
        .wdata      (steer_wdata),
        .load_value (steer_load)
    );

    // Sequencer: latch the access in IDLE, check it, then hold the request
    // until the memory answers or the wait budget is exhausted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cause_q  <= FC_NONE;
            wait_cnt <= '0;
            ea_q     <= '0;
            func3_q  <= '0;
            we_q     <= 1'b0;
            sdata_q  <= '0;
            load_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && is_mem) begin
                        ea_q     <= ea;
                        func3_q  <= func3;
                        we_q     <= is_store;
                        sdata_q  <= store_data;
                        wait_cnt <= '0;
                        if (illegal) begin
                            cause_q <= FC_ILLEGAL;
                            state   <= ST_ERR;
                        end else if (misaligned) begin
                            cause_q <= FC_MISALIGN;
                            state   <= ST_ERR;
                        end else begin
                            cause_q <= FC_NONE;
                            state   <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (mem.mem_ready) begin
                        if (!we_q)
                            load_q <= steer_load;
                        state <= ST_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        cause_q <= FC_TIMEOUT;
                        state   <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // busy rises in the same cycle a memory op is offered so fetch stalls at once.
    always_comb begin
        bus_active    = (state == ST_BUS);
        busy          = bus_active || (rst && (state == ST_IDLE) && start && is_mem);
        done          = (state == ST_DONE);
        wb_en         = done && !we_q;
        fault         = (state == ST_ERR);
        fault_cause   = fault ? cause_q : FC_NONE;
        load_data     = load_q;
        mem.mem_req   = bus_active;
        mem.mem_we    = bus_active && we_q;
        mem.mem_addr  = bus_active ? {ea_q[31:2], 2'b00} : 32'h0;
        mem.mem_wdata = bus_active ? steer_wdata : 32'h0;
        mem.mem_be    = bus_active ? steer_be : 4'h0;
    end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Multi-cycle load/store sequencer for the RV32I core.
- Accepts a decoded LOAD (0000011) or STORE (0100011) with rs1/rs2 values and the 12-bit immediate, and computes the effective address.
- Checks alignment and func3 legality, then runs a req/ready handshake on the data-memory port, including byte-lane steering and load sign/zero extension.
- Stalls the core via busy until the access completes or faults.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_req may wait for mem_ready before timeout fault (>=1).
TCNT_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter (derived, not overridden).

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  decoded instruction valid this cycle
opcode  in  7  decoded opcode
func3  in  3  decoded func3
base_addr  in  32  rs1 value
immediate  in  12  raw I/S immediate, sign-extended internally
store_data  in  32  rs2 value
busy  out  1  stall PC/fetch
done  out  1  one-cycle completion pulse
wb_en  out  1  one-cycle register-file write enable (loads only, coincident with done)
load_data  out  32  extended load result, valid when wb_en=1
fault  out  1  one-cycle fault pulse
fault_cause  out  2  01 misaligned, 10 illegal func3, 11 bus timeout; valid with fault
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({ea[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_ready  in  1  bus accepts/completes transfer this cycle
mem_rdata  in  32  read data, valid when mem_ready=1

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; counter and latched registers 0. Reset mid-transfer drops mem_req immediately. No completion or fault is reported.
- Effective address: ea = base_addr + {{20{imm[11]}}, imm], modulo 2^32. Wrap-around is legal.
- FSM states: IDLE, BUS, DONE, ERR. All bus outputs decode from registered state and latched registers.
- IDLE:
  - start=1 with non-memory opcode: ignored; stay IDLE; busy=0.
  - start=1 with LOAD/STORE: busy=1 combinationally in the same cycle. Latch ea, func3, we, wdata, be.
  - Illegal func3 (load 011/110/111; store 011-111): go to ERR with cause 10. Illegal func3 takes priority over misalignment.
  - Misaligned (H/HU with ea[0]=1; W with ea[1:0]!=0): go to ERR with cause 01.
  - Otherwise go to BUS; counter cleared.
- BUS:
  - mem_req=1 with stable mem_we/addr/wdata/be; busy=1.
  - mem_ready=1: loads capture the extended result into load_data; go to DONE.
  - No mem_ready and counter==TIMEOUT_CYCLES-1: go to ERR with cause 11. Otherwise counter++.
  - mem_ready takes priority over timeout in the same cycle.
- DONE (1 cycle): done=1; wb_en=1 if load; busy=0; mem_req=0; go to IDLE. A start in this cycle is ignored; the core re-presents it next cycle.
- ERR (1 cycle): fault=1 with cause; busy=0; done=0; wb_en=0; go to IDLE.
- start in BUS/DONE/ERR: ignored.
- Latency: start at cycle 0, mem_req at cycle 1. Ready at cycle N gives done at N+1. Minimum total is 3 cycles.
- Lane steering, with off=ea[1:0]:
  - SB: be=0001<<off, wdata={4{rs2[7:0]}}.
  - SH: be=0011<<off, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
  - Loads: be=1111. LB/LBU extract byte off; LH/LHU extract half off[1]. Sign- or zero-extend per func3[2].
- load_data holds its value until the next load completes.

Decomposition:
- lsu_pkg:
  - OP_LOAD and OP_STORE constants.
  - func3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - lsu_state_t enum.
  - fault_cause_t enum.
- Sub-module lsu_align (combinational): store be/wdata generation and load extraction/extension. It is instantiated once, and it owns all lane logic.

Test Plan:
- SW: base=0x1000, imm=0x004, rs2=0xDEADBEEF, ready at 2nd BUS cycle -> mem_addr=0x1004, be=1111, we=1; done at cycle 3; wb_en=0.
- LB: base=0x2000, imm=0x003, rdata=0x80FF_1234 -> be=1111, load_data=0xFFFFFF80, wb_en=1. Same access as LBU -> 0x00000080.
- SH: base=0x0, imm=0xFFE (-2) -> ea=0xFFFFFFFE (wrap), mem_addr=0xFFFFFFFC, be=1100, wdata={2{rs2[15:0]}}.
- LW: ea=0x1002 -> no mem_req; fault pulse with cause 01 at cycle 1. Load func3=011 -> cause 10.
- mem_ready held low -> mem_req for exactly TIMEOUT_CYCLES cycles, then fault cause 11, then IDLE. Drop rst mid-BUS -> mem_req=0 immediately, with no done or fault.
- start with opcode 0110011 -> busy=0, no mem_req. start asserted during BUS -> ignored, only one transfer occurs.
